// File: rtl/clk_mon.sv
// Clock monitor: measures the period of an asynchronous mon_clk in clk_in cycles,
// tracks lock against an expected period and flags a stopped clock.
module clk_mon #(
    parameter int CNT_WIDTH  = 8,
    parameter int EXP_PERIOD = 8,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 mon_clk,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 locked,
    output logic                 timeout
);

    localparam logic [CNT_WIDTH:0]   PER_MAX = {1'b0, {CNT_WIDTH{1'b1}}};
    localparam logic [CNT_WIDTH-1:0] CNT_TO  = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [CNT_WIDTH:0]   EXP_V   = (CNT_WIDTH+1)'(EXP_PERIOD);
    localparam logic [CNT_WIDTH:0]   TOL_V   = (CNT_WIDTH+1)'(TOL);
    localparam logic [3:0]           LOCK_V  = 4'(LOCK_COUNT);

    typedef enum logic {IDLE, MEAS} state_t;

    state_t               state;
    logic                 s1, s2, s3;
    logic                 rise;
    logic [CNT_WIDTH-1:0] cnt;
    logic [3:0]           good;
    logic [CNT_WIDTH-1:0] new_period;
    logic [3:0]           good_inc;
    logic                 match;

    function automatic logic [CNT_WIDTH-1:0] sat_period(input logic [CNT_WIDTH:0] v);
        return (v > PER_MAX) ? PER_MAX[CNT_WIDTH-1:0] : v[CNT_WIDTH-1:0];
    endfunction

    function automatic logic in_tol(input logic [CNT_WIDTH-1:0] p);
        logic [CNT_WIDTH:0] pe;
        logic [CNT_WIDTH:0] d;
        pe = {1'b0, p};
        d  = (pe >= EXP_V) ? pe - EXP_V : EXP_V - pe;
        return d <= TOL_V;
    endfunction

    // Synchroniser stage: s1/s2 resolve metastability, s3 delays for edge detect
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise       = s2 & ~s3;
    assign new_period = sat_period({1'b0, cnt} + (CNT_WIDTH+1)'(1));
    assign match      = in_tol(new_period);
    assign good_inc   = (good == LOCK_V) ? good : good + 4'd1;

    // Measurement stage: period counter, lock tracking and stopped-clock detection
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            good         <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state   <= MEAS;
                        timeout <= 1'b0;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period       <= new_period;
                        period_valid <= 1'b1;
                        cnt          <= '0;
                        if (match) begin
                            good <= good_inc;
                            if (good_inc == LOCK_V)
                                locked <= 1'b1;
                        end else begin
                            good   <= '0;
                            locked <= 1'b0;
                        end
                    end else if (cnt == CNT_TO) begin
                        // mon_clk presumed stopped; next edge only re-arms
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        good    <= '0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_mon.sv
// Directed bench for clk_mon: nominal lock, tolerance edges, stopped clock,
// mid-measurement reset and a narrow-counter saturation instance.
module tb_clk_mon;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       mon_clk = 1'b0;
    logic       mon_clk_b = 1'b0;
    logic [7:0] period;
    logic       pv, locked, timeout;
    logic [3:0] period_b;
    logic       pv_b, locked_b, timeout_b;

    clk_mon dut_a (
        .clk_in(clk_in), .rst(rst), .mon_clk(mon_clk),
        .period(period), .period_valid(pv), .locked(locked), .timeout(timeout)
    );

    clk_mon #(.CNT_WIDTH(4)) dut_b (
        .clk_in(clk_in), .rst(rst), .mon_clk(mon_clk_b),
        .period(period_b), .period_valid(pv_b), .locked(locked_b), .timeout(timeout_b)
    );

    typedef struct {
        int per;
        int eper;
        bit elock;
    } vec_t;

    typedef struct {
        logic [31:0] per;
        logic        lock;
        logic        to;
    } pulse_t;

    vec_t   vec[32];
    pulse_t qa[$];
    pulse_t qb[$];
    int     total = 0;
    int     bad = 0;
    int     dbl = 0;
    int     to_b_seen = 0;
    logic   pv_q = 1'b0;
    logic   pvb_q = 1'b0;

    always #5 clk_in = ~clk_in;

    // Pulse recorder, sampled mid-cycle
    always @(negedge clk_in) begin
        if (pv === 1'b1) qa.push_back('{32'(period), locked, timeout});
        if (pv_b === 1'b1) qb.push_back('{32'(period_b), locked_b, timeout_b});
        if (pv === 1'b1 && pv_q === 1'b1) dbl++;
        if (pv_b === 1'b1 && pvb_q === 1'b1) dbl++;
        if (timeout_b === 1'b1) to_b_seen++;
        pv_q  = pv;
        pvb_q = pv_b;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic set_mon(input bit b, input logic v);
        if (b) mon_clk_b = v;
        else   mon_clk = v;
    endtask

    task automatic mon_per(input int p, input bit b);
        set_mon(b, 1'b1);
        tick(p / 2);
        set_mon(b, 1'b0);
        tick(p - p / 2);
    endtask

    task automatic close_edge(input bit b);
        set_mon(b, 1'b1);
        tick(3);
    endtask

    task automatic compare(input int lo, input int hi, input bit b);
        int     n;
        int     sz;
        pulse_t e;
        @(negedge clk_in);
        #1;
        n  = hi - lo + 1;
        sz = b ? qb.size() : qa.size();
        check($sformatf("pulse count [%0d..%0d]", lo, hi), sz, n);
        for (int i = 0; i < n; i++) begin
            if (i < sz) begin
                e = b ? qb[i] : qa[i];
                check($sformatf("pulse %0d period", lo + i), e.per, vec[lo + i].eper);
                check($sformatf("pulse %0d locked", lo + i), {31'd0, e.lock}, {31'd0, vec[lo + i].elock});
                check($sformatf("pulse %0d timeout", lo + i), {31'd0, e.to}, 0);
            end
        end
        if (b) qb.delete();
        else   qa.delete();
    endtask

    initial begin
        int p1[21] = '{8, 8, 8, 8, 10, 10, 10, 8, 8, 8, 8, 10, 8, 9, 7, 8, 10, 8, 8, 8, 8};
        bit l1[21] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 21; i++) vec[i] = '{p1[i], p1[i], l1[i]};
        vec[21] = '{8, 8, 0};
        vec[22] = '{8, 8, 0};
        vec[23] = '{8, 8, 0};
        vec[24] = '{8, 8, 1};
        vec[25] = '{8, 8, 0};
        vec[26] = '{8, 8, 0};
        for (int i = 27; i < 32; i++) vec[i] = '{15, 15, 0};

        // reset state
        rst = 1'b1;
        tick(2);
        check("reset period", period, 0);
        check("reset period_valid", pv, 0);
        check("reset locked", locked, 0);
        check("reset timeout", timeout, 0);
        check("reset period_b", period_b, 0);
        rst = 1'b0;

        // nominal lock, out of tolerance, jitter boundary
        for (int i = 0; i < 21; i++) mon_per(vec[i].per, 1'b0);
        close_edge(1'b0);
        check("last pulse valid", pv, 1);
        mon_clk = 1'b0;
        compare(0, 20, 1'b0);

        // stopped clock: timeout exactly 255 cycles after the last counted rise
        tick(254);
        check("timeout before 255", timeout, 0);
        check("locked before 255", locked, 1);
        tick(1);
        check("timeout at 255", timeout, 1);
        check("locked at timeout", locked, 0);
        check("period kept", period, 8);
        check("no pulse while stopped", qa.size(), 0);

        // restart: first rise only clears timeout
        tick(3);
        mon_clk = 1'b1;
        tick(2);
        check("timeout held pre-rise", timeout, 1);
        tick(1);
        check("timeout cleared", timeout, 0);
        check("no pulse on restart", pv, 0);
        tick(1);
        mon_clk = 1'b0;
        tick(4);
        for (int i = 22; i < 25; i++) mon_per(vec[i].per, 1'b0);
        close_edge(1'b0);
        compare(21, 24, 1'b0);

        // reset three cycles after a pulse while locked
        tick(2);
        check("locked before reset", locked, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        mon_clk = 1'b0;
        check("mid reset period", period, 0);
        check("mid reset period_valid", pv, 0);
        check("mid reset locked", locked, 0);
        check("mid reset timeout", timeout, 0);
        tick(4);
        mon_per(8, 1'b0);
        check("no pulse on arming edge", qa.size(), 0);
        mon_per(8, 1'b0);
        close_edge(1'b0);
        mon_clk = 1'b0;
        compare(25, 26, 1'b0);

        // narrow counter: period 15 on a 4-bit counter, rise beats timeout
        for (int i = 27; i < 32; i++) mon_per(vec[i].per, 1'b1);
        close_edge(1'b1);
        mon_clk_b = 1'b0;
        compare(27, 31, 1'b1);
        check("narrow timeout never seen", to_b_seen, 0);
        check("narrow locked", locked_b, 0);

        check("single-cycle period_valid", dbl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_mon.md
# clk_mon

Clock monitor that measures the period of a divided clock (`mon_clk`) in units of the system clock `clk_in`. The measurement confirms the divided clock stays within tolerance of its expected period. The block sits beside the clock divider and consumes its output as an asynchronous input, resynchronised into `clk_in`. It reports each measured period and a lock indication, and flags a stopped clock with a timeout.

## Interface
- `CNT_WIDTH`, 8: period counter and `period` output width.
- `EXP_PERIOD`, 8: expected `mon_clk` period in `clk_in` cycles. Legal range is 4 to 2^CNT_WIDTH-2. The default matches a 50 MHz `clk_in` divided by toggle-every-4.
- `TOL`, 1: allowed absolute deviation from `EXP_PERIOD`, in cycles. Must be less than `EXP_PERIOD`.
- `LOCK_COUNT`, 4: consecutive in-tolerance periods needed to assert `locked`. Range 1 to 15.
- `clk_in`, input, 1: system clock; all logic on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `mon_clk`, input, 1: monitored clock, asynchronous to `clk_in`.
- `period`, output, CNT_WIDTH: last measured period in `clk_in` cycles.
- `period_valid`, output, 1: one-cycle pulse when `period` updates.
- `locked`, output, 1: `mon_clk` period has been in tolerance for LOCK_COUNT consecutive periods.
- `timeout`, output, 1: no `mon_clk` rising edge within 2^CNT_WIDTH-1 cycles.

## Operation
- **Synchroniser**
  - Two flops `s1`, `s2` on `mon_clk`, plus a third flop `s3`.
  - `rise = s2 & ~s3`.
  - All three flops reset to 0.
- **State machine** (two states)
  - IDLE, the reset state.
    - Counter held at 0.
    - On `rise`: go to MEAS and clear `timeout`. No `period_valid` is produced for this first edge.
  - MEAS: counter `cnt` increments every cycle.
  - MEAS with `rise`:
    - `period <= cnt+1`, saturated at 2^CNT_WIDTH-1.
    - `period_valid <= 1` and `cnt <= 0`.
    - Stay in MEAS.
  - MEAS with no `rise` and `cnt == 2^CNT_WIDTH-2`:
    - `timeout <= 1`, `locked <= 0`, good count cleared.
    - `cnt <= 0`, go to IDLE.
  - If `rise` and the timeout condition occur in the same cycle, `rise` wins.
- **Lock tracking**, evaluated only on cycles that produce `period_valid`.
  - `match = (|new_period - EXP_PERIOD| <= TOL)`, with the subtraction done unsigned on CNT_WIDTH+1 bits.
  - If `match`, `good` increments, saturating at LOCK_COUNT. `locked <= 1` when the incremented value equals LOCK_COUNT.
  - If `!match`, `good <= 0` and `locked <= 0`.
  - `locked` and `good` change in the same cycle as the corresponding `period_valid`.
- **Reset values:** `period=0`, `period_valid=0`, `locked=0`, `timeout=0`, state IDLE, `cnt=0`, `good=0`.
- **Reset mid-measurement:**
  - Any partial count is discarded.
  - The first `mon_clk` edge after reset only arms the monitor (IDLE to MEAS).
  - Lock is re-acquired from zero.

## Timing
- All outputs are registered. There is no combinational path from `mon_clk` to any output.
- **Edge-to-output latency:**
  - `mon_clk` rises between edges k-1 and k.
  - `s1` captures at edge k and `s2` at edge k+1.
  - `period_valid`, `period` and `locked` update at edge k+2.
  - The value is fixed at 2 cycles after capture; synchroniser metastability may add one cycle.
- **Period accuracy:** for consecutive captured edges N cycles apart, `period = N`. A ±1 capture jitter is inherent and is covered by `TOL`.
- `period_valid` is high for exactly one `clk_in` cycle per measured period. Back-to-back pulses are impossible because EXP_PERIOD ≥ 4.
- `period` holds its value between pulses and is not cleared by a timeout.
- `timeout`:
  - Asserts 2^CNT_WIDTH-1 cycles after the last counted `rise`, which is 255 cycles for the defaults.
  - Stays high until the first `rise` seen in IDLE.
- `rst` takes effect on the edge where it is sampled high. Outputs show their reset values in the following cycle.

## Test plan
- **Nominal lock.** `mon_clk` period 8 (4 high, 4 low) after reset.
  - First edge arms only.
  - Then `period=8` with a `period_valid` pulse every 8 cycles.
  - `locked=1` on the 4th pulse; `timeout=0` throughout.
- **Out of tolerance.** `mon_clk` period 10 with TOL=1.
  - `period=10` every 10 cycles; `locked` stays 0.
  - Switch to period 8: `locked` rises on the 4th period-8 pulse.
- **Jitter boundary.** Periods 8, 9, 7, 8 give `locked=1` on the 4th pulse. A following period of 10 gives `locked=0` in the same cycle as its `period_valid`.
- **Stopped clock.**
  - After lock, hold `mon_clk` low: `timeout=1` and `locked=0` exactly 255 cycles after the last counted `rise`. `period` keeps 8.
  - Restart: `timeout` clears on the first detected rise with no pulse. The next pulse reports 8, and lock returns after 4 pulses.
- **Reset mid-measure.**
  - Assert `rst` for one cycle 3 cycles after a pulse while locked: next cycle all outputs are 0.
  - The first post-reset edge produces no pulse; the second edge reports `period=8`.
- **Saturation.** Set CNT_WIDTH=4 and `mon_clk` period 15: `period=15` each pulse, no timeout, `locked=0`.
